// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Size codes, FSM states and the registered request record.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam int         MASK_W    = 8;
   localparam logic [3:0] WORD_MASK = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sgn;
   } req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store mask/replication, load extract/extend, misalign detect.
// Purely combinational; no state and no flow control.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]        i_size,
   input  logic [1:0]        i_off,
   input  logic              i_signed,
   input  logic [31:0]       i_wdata,
   input  logic [31:0]       i_rdata,
   output logic [MASK_W-1:0] o_wmask,
   output logic [31:0]       o_wdata,
   output logic [31:0]       o_rdata,
   output logic              o_misalign
);

   logic [31:0] w_shift;
   logic [3:0]  w_mask4;

   always_comb begin
      w_shift    = i_rdata >> {i_off, 3'b000};
      w_mask4    = '0;
      o_wdata    = '0;
      o_rdata    = '0;
      o_misalign = 1'b0;
      case (i_size)
         SZ_B: begin
            w_mask4 = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
         end
         SZ_H: begin
            o_misalign = i_off[0];
            w_mask4    = 4'b0011 << i_off;
            o_wdata    = {2{i_wdata[15:0]}};
            o_rdata    = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
         end
         SZ_W: begin
            o_misalign = (i_off != 2'b00);
            w_mask4    = WORD_MASK;
            o_wdata    = i_wdata;
            o_rdata    = i_rdata;
         end
         default: o_misalign = 1'b1;
      endcase
   end

   // Upper mask nibble exists only to match the memory block's port width.
   assign o_wmask = {{(MASK_W-4){1'b0}}, w_mask4};

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request in flight, IDLE -> ACCESS (MEM_LAT cycles) -> RESP; misaligned skips ACCESS.
// Request accepted only in IDLE; response held in RESP until out_ready.
module lsu
   import lsu_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wen,
   input  logic [31:0]       in_addr,
   input  logic [31:0]       in_wdata,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_rdata,
   output logic              out_err,
   output logic              mem_valid,
   output logic [31:0]       mem_raddr,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wen,
   output logic [31:0]       mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic [MASK_W-1:0] mem_wmask
);

   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   req_t              r_req;
   req_t              w_req_in;
   req_t              w_req_cur;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic              w_hs;
   logic [MASK_W-1:0] w_wmask;
   logic [31:0]       w_wdata;
   logic [31:0]       w_rdata;
   logic              w_misalign;

   assign w_req_in.wen   = in_wen;
   assign w_req_in.addr  = in_addr;
   assign w_req_in.wdata = in_wdata;
   assign w_req_in.size  = in_size;
   assign w_req_in.sgn   = in_signed;

   // The aligner sees the live request in IDLE (for the misalign decision) and the held one afterwards.
   assign w_req_cur = (r_state == ST_IDLE) ? w_req_in : r_req;
   assign w_hs      = in_valid & (r_state == ST_IDLE);

   lsu_align u_align (
      .i_size     (w_req_cur.size),
      .i_off      (w_req_cur.addr[1:0]),
      .i_signed   (w_req_cur.sgn),
      .i_wdata    (w_req_cur.wdata),
      .i_rdata    (mem_rdata),
      .o_wmask    (w_wmask),
      .o_wdata    (w_wdata),
      .o_rdata    (w_rdata),
      .o_misalign (w_misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      mem_valid   = 1'b0;
      mem_raddr   = '0;
      mem_waddr   = '0;
      mem_wen     = 1'b0;
      mem_wdata   = '0;
      mem_wmask   = '0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (w_hs) begin
               w_state_nxt = w_misalign ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_valid = 1'b1;
            mem_raddr = {r_req.addr[31:2], 2'b00};
            mem_waddr = {r_req.addr[31:2], 2'b00};
            if (r_req.wen) begin
               mem_wdata = w_wdata;
               mem_wmask = w_wmask;
               // Strobe only in the last cycle so a long access writes once.
               mem_wen   = (r_cnt == '0);
            end
            if (r_cnt == '0) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_req   <= w_req_in;
                  r_err   <= w_misalign;
                  r_rdata <= '0;
                  r_cnt   <= w_misalign ? '0 : CNT_LOAD;
               end
            end
            ST_ACCESS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_ONE;
               end else begin
                  r_rdata <= r_req.wen ? '0 : w_rdata;
               end
            end
            ST_RESP: begin
               if (out_ready) begin
                  r_rdata <= '0;
                  r_err   <= 1'b0;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign out_rdata = r_rdata;
   assign out_err   = r_err;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: two instances (MEM_LAT 1 and 3) against a byte-level reference model and memory.
module tb_lsu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid [2];
   logic        in_ready [2];
   logic        in_wen   [2];
   logic        in_signed[2];
   logic        out_valid[2];
   logic        out_ready[2];
   logic        out_err  [2];
   logic        mem_valid[2];
   logic        mem_wen  [2];
   logic [31:0] in_addr  [2];
   logic [31:0] in_wdata [2];
   logic [31:0] out_rdata[2];
   logic [31:0] mem_raddr[2];
   logic [31:0] mem_waddr[2];
   logic [31:0] mem_rdata[2];
   logic [31:0] mem_wdata[2];
   logic [1:0]  in_size  [2];
   logic [7:0]  mem_wmask[2];

   logic [31:0] mem_arr[2][16];
   logic [31:0] ref_mem[2][16];
   logic        pre_we;
   int          pre_d;
   logic [3:0]  pre_idx;
   logic [31:0] pre_dat;

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lsu #(.MEM_LAT(g == 0 ? 1 : 3)) u_lsu (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_wen    (in_wen[g]),
         .in_addr   (in_addr[g]),
         .in_wdata  (in_wdata[g]),
         .in_size   (in_size[g]),
         .in_signed (in_signed[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_rdata (out_rdata[g]),
         .out_err   (out_err[g]),
         .mem_valid (mem_valid[g]),
         .mem_raddr (mem_raddr[g]),
         .mem_rdata (mem_rdata[g]),
         .mem_wen   (mem_wen[g]),
         .mem_waddr (mem_waddr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_wmask (mem_wmask[g])
      );
      assign mem_rdata[g] = mem_arr[g][mem_raddr[g][5:2]];
   end

   // Behavioural memory block: combinational read, masked write on the strobe.
   always @(posedge clk) begin
      if (pre_we) mem_arr[pre_d][pre_idx] <= pre_dat;
      for (int d = 0; d < 2; d++) begin
         if (mem_wen[d]) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_wmask[d][b]) mem_arr[d][mem_waddr[d][5:2]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic preload(input int d, input logic [3:0] idx, input logic [31:0] dat);
      @(negedge clk);
      pre_we = 1'b1; pre_d = d; pre_idx = idx; pre_dat = dat;
      ref_mem[d][idx] = dat;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   task automatic chk_reset_vals(input int d);
      chk("rst_in_ready",  32'(in_ready[d]),  32'd1);
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_out_rdata", out_rdata[d],      32'd0);
      chk("rst_out_err",   32'(out_err[d]),   32'd0);
      chk("rst_mem_valid", 32'(mem_valid[d]), 32'd0);
      chk("rst_mem_wen",   32'(mem_wen[d]),   32'd0);
      chk("rst_mem_raddr", mem_raddr[d],      32'd0);
      chk("rst_mem_waddr", mem_waddr[d],      32'd0);
      chk("rst_mem_wdata", mem_wdata[d],      32'd0);
      chk("rst_mem_wmask", 32'(mem_wmask[d]), 32'd0);
   endtask

   task automatic run_txn(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sgn, input int rdy_dly);
      int          lat, n, off, first_out, vcount, wcount;
      logic        err;
      logic [3:0]  idx;
      logic [31:0] aligned, exp_mask, exp_wdata, exp_rdata, word, got_rd;
      lat     = lat_of(d);
      off     = int'(addr[1:0]);
      n       = 1 << size;
      idx     = addr[5:2];
      aligned = addr & 32'hFFFF_FFFC;
      err     = (size == 2'd3) || ((off % n) != 0);
      word    = ref_mem[d][idx];
      exp_mask  = 0;
      exp_wdata = 0;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + n) exp_mask[i] = 1'b1;
         exp_wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
      end
      exp_rdata = 0;
      if (!err && !wen) begin
         for (int i = 0; i < n; i++) exp_rdata[8*i +: 8] = word[8*(off+i) +: 8];
         if (sgn && n < 4 && exp_rdata[8*n-1]) exp_rdata = exp_rdata | ~((32'd1 << (8*n)) - 32'd1);
      end

      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
      in_valid[d] = 1'b1; in_wen[d] = wen; in_addr[d] = addr; in_wdata[d] = wdata;
      in_size[d] = size; in_signed[d] = sgn; out_ready[d] = 1'b0;
      @(posedge clk);
      #1;
      // Junk request held while busy; it must be ignored.
      in_valid[d] = 1'($urandom_range(0, 1)); in_addr[d] = $urandom; in_wdata[d] = $urandom;
      in_size[d] = 2'($urandom_range(0, 3)); in_wen[d] = 1'($urandom_range(0, 1));

      first_out = 0; vcount = 0; wcount = 0;
      for (int k = 1; k <= 20 && first_out == 0; k++) begin
         @(negedge clk);
         if (mem_valid[d]) begin
            vcount++;
            chk("mem_raddr", mem_raddr[d], aligned);
            chk("mem_waddr", mem_waddr[d], aligned);
         end
         if (mem_wen[d]) begin
            wcount++;
            chk("wen_cycle", k,              lat);
            chk("mem_wmask", 32'(mem_wmask[d]), exp_mask);
            chk("mem_wdata", mem_wdata[d],   exp_wdata);
         end
         chk("in_ready_busy", 32'(in_ready[d]), 32'd0);
         if (out_valid[d]) first_out = k;
      end
      chk("out_valid_lat",  first_out, err ? 1 : lat + 1);
      chk("mem_valid_cyc",  vcount,    err ? 0 : lat);
      chk("mem_wen_pulses", wcount,    (!err && wen) ? 1 : 0);
      chk("out_err",        32'(out_err[d]), 32'(err));
      chk("out_rdata",      out_rdata[d],    exp_rdata);
      chk("mem_idle_resp",  32'(mem_valid[d]) | mem_raddr[d] | mem_waddr[d], 32'd0);
      got_rd = out_rdata[d];

      for (int j = 0; j < rdy_dly; j++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(out_valid[d]), 32'd1);
         chk("hold_out_rdata", out_rdata[d],      got_rd);
         chk("hold_out_err",   32'(out_err[d]),   32'(err));
         chk("hold_in_ready",  32'(in_ready[d]),  32'd0);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      @(negedge clk);
      chk("post_in_ready",  32'(in_ready[d]),  32'd1);
      chk("post_out_valid", 32'(out_valid[d]), 32'd0);
      out_ready[d] = 1'b0;

      if (!err && wen) begin
         for (int i = 0; i < 4; i++) if (exp_mask[i]) ref_mem[d][idx][8*i +: 8] = exp_wdata[8*i +: 8];
      end
      chk("mem_word", mem_arr[d][idx], ref_mem[d][idx]);
   endtask

   task automatic reset_mid_store;
      @(negedge clk);
      in_valid[1] = 1'b1; in_wen[1] = 1'b1; in_addr[1] = 32'h8000_0020; in_wdata[1] = 32'h5A5A_1234;
      in_size[1] = 2'd2; in_signed[1] = 1'b0; out_ready[1] = 1'b0;
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      @(negedge clk);
      chk("rst_pre_access", 32'(mem_valid[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals(1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("rst_hold_wen",   32'(mem_wen[1]),   32'd0);
         chk("rst_hold_valid", 32'(out_valid[1]), 32'd0);
      end
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("rel_out_valid", 32'(out_valid[1]), 32'd0);
         chk("rel_mem_valid", 32'(mem_valid[1]), 32'd0);
      end
      chk("rst_no_write", mem_arr[1][8], ref_mem[1][8]);
      run_txn(1, 1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      int          d;
      logic        wen, sgn;
      logic [1:0]  size;
      logic [31:0] addr;
      rst_n  = 1'b0;
      pre_we = 1'b0; pre_d = 0; pre_idx = '0; pre_dat = '0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; in_wen[i] = 1'b0; in_addr[i] = '0; in_wdata[i] = '0;
         in_size[i] = '0; in_signed[i] = 1'b0; out_ready[i] = 1'b0;
      end
      #1;
      chk_reset_vals(0);
      chk_reset_vals(1);
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 16; j++) preload(i, 4'(j), $urandom);
      preload(0, 4'd4, 32'h1234_80FF);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);
      run_txn(0, 1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 1);
      run_txn(0, 1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 0);
      run_txn(0, 1'b0, 32'h8000_0011, 32'h0,         2'd0, 1'b1, 0);
      run_txn(0, 1'b0, 32'h8000_0011, 32'h0,         2'd0, 1'b0, 2);
      run_txn(0, 1'b0, 32'h8000_0012, 32'h0,         2'd1, 1'b1, 0);
      run_txn(0, 1'b0, 32'h8000_0010, 32'h0,         2'd1, 1'b1, 0);
      run_txn(0, 1'b0, 32'h8000_0002, 32'h0,         2'd2, 1'b0, 0);
      run_txn(0, 1'b0, 32'h8000_0010, 32'h0,         2'd3, 1'b1, 1);
      run_txn(1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 2'd2, 1'b0, 5);
      reset_mid_store();

      for (int t = 0; t < 80; t++) begin
         d    = $urandom_range(0, 1);
         wen  = 1'($urandom_range(0, 1));
         sgn  = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 2) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
         run_txn(d, wen, addr, $urandom, size, sgn, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
